// File: rtl/cnn_fp16_pkg.sv
// cnn_fp16_pkg: FP16 constants and element-wise helpers shared by the conv, pool and FC stages.
package cnn_fp16_pkg;
    localparam int DATA_WIDTH = 16;
    typedef logic [DATA_WIDTH-1:0] fp16_t;
    localparam fp16_t FP16_ZERO = 16'h0000;
    localparam fp16_t FP16_PINF = 16'h7C00;
    localparam fp16_t FP16_ONE  = 16'h3C00;

    // Clearing every sign-set pattern also folds -0 and negative NaNs to +0.
    function automatic fp16_t fp16_relu(input fp16_t x);
        return x[DATA_WIDTH-1] ? FP16_ZERO : x;
    endfunction

    // Non-negative halves order like unsigned ints; +NaN sorts above +Inf and so propagates.
    function automatic fp16_t fp16_max_nonneg(input fp16_t a, input fp16_t b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/pool_line_buffer.sv
// pool_line_buffer: half-row store of horizontal pair maxima with one write port and async read.
module pool_line_buffer #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 14,
    localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [AW-1:0]         waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]         raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/relu_maxpool_stream.sv
// relu_maxpool_stream: streaming FP16 ReLU followed by 2x2/stride-2 max-pool over a WxH map.
// Even rows park pair maxima in the line buffer; odd rows combine them and emit one pooled pixel.
module relu_maxpool_stream #(
    parameter int DATA_WIDTH = cnn_fp16_pkg::DATA_WIDTH,
    parameter int W          = 28,
    parameter int H          = 28
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  frame_done
);
    import cnn_fp16_pkg::*;

    localparam int CW   = $clog2(W);
    localparam int RW   = $clog2(H);
    localparam int HALF = W / 2;
    localparam int AW   = (HALF > 1) ? $clog2(HALF) : 1;

    if (W < 2 || (W % 2) != 0) begin : g_bad_w
        $error("relu_maxpool_stream: W must be even and >= 2");
    end
    if (H < 2 || (H % 2) != 0) begin : g_bad_h
        $error("relu_maxpool_stream: H must be even and >= 2");
    end
    if (DATA_WIDTH != cnn_fp16_pkg::DATA_WIDTH) begin : g_bad_dw
        $error("relu_maxpool_stream: DATA_WIDTH must match FP16");
    end

    logic [CW-1:0]         col_q, col_d;
    logic [RW-1:0]         row_q, row_d;
    logic [DATA_WIDTH-1:0] pair_q, pair_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  frame_done_q, frame_done_d;

    logic                  acc, last_col, last_row, lb_we, emit;
    logic [AW-1:0]         lb_idx;
    logic [DATA_WIDTH-1:0] relu_px, pair_max, lb_rdata;

    pool_line_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (HALF)
    ) u_line_buf (
        .clk     (clk),
        .we_i    (lb_we),
        .waddr_i (lb_idx),
        .wdata_i (pair_max),
        .raddr_i (lb_idx),
        .rdata_o (lb_rdata)
    );

    always_comb begin
        in_ready     = !out_valid_q || out_ready;
        acc          = in_valid && in_ready;
        last_col     = col_q == CW'(W - 1);
        last_row     = row_q == RW'(H - 1);
        lb_idx       = AW'(col_q >> 1);
        relu_px      = fp16_relu(in_data);
        pair_max     = fp16_max_nonneg(pair_q, relu_px);
        lb_we        = acc && col_q[0] && !row_q[0];
        emit         = acc && col_q[0] && row_q[0];
        col_d        = acc ? (last_col ? '0 : col_q + 1'b1) : col_q;
        row_d        = (acc && last_col) ? (last_row ? '0 : row_q + 1'b1) : row_q;
        pair_d       = (acc && !col_q[0]) ? relu_px : pair_q;
        out_data_d   = emit ? fp16_max_nonneg(lb_rdata, pair_max) : out_data_q;
        out_valid_d  = emit ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
        frame_done_d = emit ? (last_row && last_col) : (out_ready ? 1'b0 : frame_done_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_q        <= '0;
            row_q        <= '0;
            pair_q       <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            pair_q       <= pair_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign frame_done = frame_done_q;
endmodule

// File: tb/tb_relu_maxpool_stream.sv
// tb_relu_maxpool_stream: directed checks on a 4x4 instance and a default 28x28 instance.
`timescale 1ns/1ps
module tb_relu_maxpool_stream;
    typedef logic [15:0] px_t;
    typedef px_t frame4_t [16];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic a_reset = 1'b0, a_in_valid = 1'b0, a_out_ready = 1'b1;
    px_t  a_in_data = '0;
    logic a_in_ready, a_out_valid, a_frame_done;
    px_t  a_out_data;

    logic b_reset = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b1;
    px_t  b_in_data = '0;
    logic b_in_ready, b_out_valid, b_frame_done;
    px_t  b_out_data;

    relu_maxpool_stream #(.DATA_WIDTH(16), .W(4), .H(4)) dut4 (
        .clk(clk), .reset(a_reset), .in_data(a_in_data), .in_valid(a_in_valid),
        .in_ready(a_in_ready), .out_data(a_out_data), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .frame_done(a_frame_done)
    );

    relu_maxpool_stream #(.DATA_WIDTH(16), .W(28), .H(28)) dut28 (
        .clk(clk), .reset(b_reset), .in_data(b_in_data), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .out_data(b_out_data), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .frame_done(b_frame_done)
    );

    px_t  b_q[$];
    logic b_fq[$];
    always @(negedge clk) begin
        if (b_out_valid === 1'b1 && b_out_ready) begin
            b_q.push_back(b_out_data);
            b_fq.push_back(b_frame_done);
        end
    end

    function automatic px_t ramp(input int i);
        int v;
        v = i * 16;
        return {1'b0, v[14:0]};
    endfunction

    function automatic px_t relu(input px_t x);
        return x[15] ? 16'h0000 : x;
    endfunction

    function automatic px_t mx(input px_t a, input px_t b);
        return (a > b) ? a : b;
    endfunction

    function automatic px_t gold(input int base, input int oi);
        int r0, c0;
        px_t m;
        r0 = (oi / 14) * 2;
        c0 = (oi % 14) * 2;
        m = 16'h0000;
        for (int dr = 0; dr < 2; dr++)
            for (int dc = 0; dc < 2; dc++)
                m = mx(m, relu(ramp(base + (r0 + dr) * 28 + c0 + dc)));
        return m;
    endfunction

    task automatic run4(input frame4_t px, output px_t od[4], output logic ofd[4],
                        output int oat[4], output int n);
        n = 0;
        for (int k = 0; k < 4; k++) begin
            od[k] = 'x;
            ofd[k] = 1'bx;
            oat[k] = -1;
        end
        for (int i = 0; i < 16; i++) begin
            a_in_data  = px[i];
            a_in_valid = 1'b1;
            @(posedge clk); #1;
            if (a_out_valid === 1'b1) begin
                if (n < 4) begin
                    od[n]  = a_out_data;
                    ofd[n] = a_frame_done;
                    oat[n] = i;
                end
                n++;
            end
        end
        a_in_valid = 1'b0;
    endtask

    task automatic feed28(input int base, input int n, input bit junk);
        for (int k = 0; k < n; k++) begin
            int g;
            b_in_data  = junk ? 16'h7BFF : ramp(base + k);
            b_in_valid = 1'b1;
            g = 0;
            @(negedge clk);
            while (b_in_ready !== 1'b1 && g < 200) begin
                g++;
                @(negedge clk);
            end
            if (b_in_ready !== 1'b1) begin
                total++; bad++;
                $display("FAIL in_ready_timeout pixel=%0d got=%b exp=1", base + k, b_in_ready);
            end
            @(posedge clk); #1;
        end
        b_in_valid = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL rst4_valid got=%b exp=0", a_out_valid); end
        total++; if (a_out_data !== 16'h0000) begin bad++; $display("FAIL rst4_data got=%h exp=0000", a_out_data); end
        total++; if (a_frame_done !== 1'b0) begin bad++; $display("FAIL rst4_fd got=%b exp=0", a_frame_done); end
        total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL rst4_in_ready got=%b exp=1", a_in_ready); end
        total++; if (b_out_valid !== 1'b0) begin bad++; $display("FAIL rst28_valid got=%b exp=0", b_out_valid); end
        total++; if (b_out_data !== 16'h0000) begin bad++; $display("FAIL rst28_data got=%h exp=0000", b_out_data); end
        total++; if (b_frame_done !== 1'b0) begin bad++; $display("FAIL rst28_fd got=%b exp=0", b_frame_done); end
        total++; if (b_in_ready !== 1'b1) begin bad++; $display("FAIL rst28_in_ready got=%b exp=1", b_in_ready); end
        repeat (2) @(posedge clk);
        #1;
        a_reset = 1'b1;
        b_reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_window;
        frame4_t px;
        px_t od[4]; logic ofd[4]; int oat[4]; int n;
        px = '{16'h3C00, 16'h4000, 16'h0000, 16'h0000,
               16'hBC00, 16'h3800, 16'h0000, 16'h0000,
               16'h0000, 16'h0000, 16'h0000, 16'h0000,
               16'h0000, 16'h0000, 16'h0000, 16'h0000};
        run4(px, od, ofd, oat, n);
        total++; if (n != 4) begin bad++; $display("FAIL win_count got=%0d exp=4", n); end
        total++; if (od[0] !== 16'h4000) begin bad++; $display("FAIL win_first got=%h exp=4000", od[0]); end
        total++; if (oat[0] != 5) begin bad++; $display("FAIL win_latency got=%0d exp=5", oat[0]); end
        total++; if (od[1] !== 16'h0000) begin bad++; $display("FAIL win_second got=%h exp=0000", od[1]); end
        total++; if (ofd[0] !== 1'b0) begin bad++; $display("FAIL win_fd_first got=%b exp=0", ofd[0]); end
        total++; if (ofd[3] !== 1'b1) begin bad++; $display("FAIL win_fd_last got=%b exp=1", ofd[3]); end
    endtask

    task automatic test_negative;
        frame4_t px;
        px_t neg[4];
        px_t od[4]; logic ofd[4]; int oat[4]; int n;
        neg = '{16'hC000, 16'hBC00, 16'h8000, 16'hFC00};
        for (int i = 0; i < 16; i++) px[i] = neg[i % 4];
        run4(px, od, ofd, oat, n);
        total++; if (n != 4) begin bad++; $display("FAIL neg_count got=%0d exp=4", n); end
        for (int k = 0; k < 4; k++) begin
            total++; if (od[k] !== 16'h0000) begin bad++; $display("FAIL neg_data[%0d] got=%h exp=0000", k, od[k]); end
            total++; if (ofd[k] !== (k == 3)) begin bad++; $display("FAIL neg_fd[%0d] got=%b exp=%b", k, ofd[k], k == 3); end
        end
    endtask

    task automatic test_nan;
        frame4_t px;
        px_t exp_o[4];
        px_t od[4]; logic ofd[4]; int oat[4]; int n;
        px = '{16'h7C00, 16'h7E00, 16'h0000, 16'h8000,
               16'h0000, 16'h0000, 16'h0000, 16'h0000,
               16'h7E00, 16'h7C00, 16'h3C00, 16'hFE00,
               16'h0000, 16'h0000, 16'h0000, 16'h0000};
        exp_o = '{16'h7E00, 16'h0000, 16'h7E00, 16'h3C00};
        run4(px, od, ofd, oat, n);
        total++; if (n != 4) begin bad++; $display("FAIL nan_count got=%0d exp=4", n); end
        for (int k = 0; k < 4; k++) begin
            total++; if (od[k] !== exp_o[k]) begin bad++; $display("FAIL nan_data[%0d] got=%h exp=%h", k, od[k], exp_o[k]); end
        end
    endtask

    task automatic test_frames;
        b_q.delete(); b_fq.delete();
        feed28(0, 784, 1'b0);
        feed28(784, 784, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        total++; if (b_q.size() != 392) begin bad++; $display("FAIL frames_count got=%0d exp=392", b_q.size()); end
        for (int i = 0; i < 392 && i < b_q.size(); i++) begin
            px_t e;
            logic efd;
            e = gold((i / 196) * 784, i % 196);
            efd = (i % 196) == 195;
            total++; if (b_q[i] !== e) begin bad++; $display("FAIL frames_data[%0d] got=%h exp=%h", i, b_q[i], e); end
            total++; if (b_fq[i] !== efd) begin bad++; $display("FAIL frames_fd[%0d] got=%b exp=%b", i, b_fq[i], efd); end
        end
    endtask

    task automatic test_backpressure;
        px_t e;
        int g;
        b_q.delete(); b_fq.delete();
        fork
            feed28(0, 784, 1'b0);
            begin
                g = 0;
                do begin
                    @(posedge clk); #1;
                    g++;
                end while (!(b_out_valid === 1'b1 && b_q.size() >= 20) && g < 2000);
                e = gold(0, b_q.size());
                total++; if (b_out_valid !== 1'b1) begin bad++; $display("FAIL stall_start got=%b exp=1", b_out_valid); end
                b_out_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    total++; if (b_in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready got=%b exp=0", b_in_ready); end
                    total++; if (b_out_valid !== 1'b1) begin bad++; $display("FAIL stall_valid got=%b exp=1", b_out_valid); end
                    total++; if (b_out_data !== e) begin bad++; $display("FAIL stall_data got=%h exp=%h", b_out_data, e); end
                    total++; if (b_frame_done !== 1'b0) begin bad++; $display("FAIL stall_fd got=%b exp=0", b_frame_done); end
                end
                @(posedge clk); #1;
                b_out_ready = 1'b1;
            end
        join
        repeat (3) @(posedge clk);
        #1;
        total++; if (b_q.size() != 196) begin bad++; $display("FAIL bp_count got=%0d exp=196", b_q.size()); end
        for (int i = 0; i < 196 && i < b_q.size(); i++) begin
            px_t ge;
            ge = gold(0, i);
            total++; if (b_q[i] !== ge) begin bad++; $display("FAIL bp_data[%0d] got=%h exp=%h", i, b_q[i], ge); end
            total++; if (b_fq[i] !== (i == 195)) begin bad++; $display("FAIL bp_fd[%0d] got=%b exp=%b", i, b_fq[i], i == 195); end
        end
    endtask

    task automatic test_reset_mid;
        b_out_ready = 1'b1;
        feed28(0, 30, 1'b1);
        total++; if (b_out_valid !== 1'b1) begin bad++; $display("FAIL pre_rst_valid got=%b exp=1", b_out_valid); end
        total++; if (b_out_data !== 16'h7BFF) begin bad++; $display("FAIL pre_rst_data got=%h exp=7bff", b_out_data); end
        #2;
        b_reset = 1'b0;
        #1;
        total++; if (b_out_valid !== 1'b0) begin bad++; $display("FAIL async_rst_valid got=%b exp=0", b_out_valid); end
        total++; if (b_out_data !== 16'h0000) begin bad++; $display("FAIL async_rst_data got=%h exp=0000", b_out_data); end
        total++; if (b_frame_done !== 1'b0) begin bad++; $display("FAIL async_rst_fd got=%b exp=0", b_frame_done); end
        @(posedge clk); #1;
        b_reset = 1'b1;
        b_q.delete(); b_fq.delete();
        feed28(0, 784, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        total++; if (b_q.size() != 196) begin bad++; $display("FAIL rst_count got=%0d exp=196", b_q.size()); end
        for (int i = 0; i < 196 && i < b_q.size(); i++) begin
            px_t ge;
            ge = gold(0, i);
            total++; if (b_q[i] !== ge) begin bad++; $display("FAIL rst_data[%0d] got=%h exp=%h", i, b_q[i], ge); end
            total++; if (b_fq[i] !== (i == 195)) begin bad++; $display("FAIL rst_fd[%0d] got=%b exp=%b", i, b_fq[i], i == 195); end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset;
        test_window;
        test_negative;
        test_nan;
        test_frames;
        test_backpressure;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/relu_maxpool_stream.md
Name: relu_maxpool_stream

Overview:
- Streaming FP16 ReLU plus 2x2/stride-2 max-pool stage. It sits directly downstream of the single-channel convolution stage.
- Consumes the convolution result map (28x28 FP16 by default) one pixel per handshake, in row-major order, first pixel = index 0.
- Emits the pooled map (14x14 by default) in row-major order. This is the LeNet C1→S2 transition.
- Holds a half-row line buffer plus one horizontal pair register; no full-frame storage.

Parameters:
- DATA_WIDTH, 16, pixel width (IEEE-754 half precision).
- W, 28, input map width; must be even (elaboration error otherwise).
- H, 28, input map height; must be even (elaboration error otherwise).

Ports:
- clk  in  1  rising-edge clock, single clock domain.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- in_data  in  DATA_WIDTH  convolution output pixel.
- in_valid  in  1  in_data valid.
- in_ready  out  1  stage can accept in_data this cycle.
- out_data  out  DATA_WIDTH  pooled pixel.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts out_data.
- frame_done  out  1  high together with out_valid on the last pooled pixel of a frame, index (H/2)*(W/2)-1.

Behaviour:
- Reset asserted (async, active-low): out_valid=0, out_data=0, frame_done=0, col=0, row=0, pair register=0. The line buffer is not cleared; an even row always overwrites it before any read.
- Accept rule: a pixel transfers when in_valid && in_ready. in_ready = !out_valid || out_ready, combinational and identical every cycle, regardless of pixel position.
- ReLU: r = in_data[15] ? 16'h0000 : in_data. This maps -0 and negative NaN to 0.
- Max: operands are non-negative after ReLU, so compare as unsigned 16-bit integers. Positive NaN (>16'h7C00) wins over +Inf and propagates. Tie returns either operand; the bit patterns are equal.
- Counters:
  - col runs 0..W-1 and increments on each accepted pixel.
  - At col=W-1, col wraps to 0 and row increments.
  - At row=H-1 and col=W-1, both wrap to 0. The next accepted pixel starts a new frame; no idle gap is required.
- Per accepted pixel:
  - Even col: pair_reg <= r.
  - Odd col: m = max(pair_reg, r).
  - Odd col, even row: linebuf[col>>1] <= m.
  - Odd col, odd row: out_data <= max(linebuf[col>>1], m); out_valid <= 1; frame_done <= (row==H-1 && col==W-1).
- Latency: out_valid rises on the clock edge that accepts the window's bottom-right pixel (1 cycle).
- Output hold: while out_valid && !out_ready, out_data and frame_done stay stable and in_ready=0.
- Output clear: on out_ready with no new result in the same cycle, out_valid <= 0 and frame_done <= 0.
- Simultaneous out_ready and a completing input: the new result loads and out_valid stays 1 (full throughput, 1 pixel/cycle in).
- Reset mid-frame: all partial state is discarded. The next accepted pixel is treated as frame index 0.
- Line buffer: W/2 entries x DATA_WIDTH, 1 write port, 1 combinational read port. Width of col/row counters is $clog2(W) and $clog2(H).

Decomposition:
- Shared package cnn_fp16_pkg holds:
  - DATA_WIDTH;
  - FP16 constants: FP16_ZERO=16'h0000, FP16_PINF=16'h7C00, FP16_ONE=16'h3C00;
  - function fp16_relu;
  - function fp16_max_nonneg.
  The convolution and fully-connected stages reuse this package.
- One sub-module is natural: pool_line_buffer. It is a W/2-deep register array with write-enable, write index, read index and async read. The counters, pair register and output register stay in the top.

Test Plan:
- W=4,H=4, window {3C00,4000 / BC00,3800} (1.0, 2.0, -1.0, 0.5) at top-left, with other pixels 0000 and out_ready=1 → first out_data=4000. out_valid is high exactly 1 cycle after the 6th accepted pixel (row1,col1).
- W=4,H=4, all inputs negative (C000, BC00, 8000, FC00) → 4 outputs all 0000; frame_done high only on the 4th output.
- Positive NaN 7E00 in a window with 7C00 → output 7E00. Window {0000,8000,0000,0000} → 0000.
- Default 28x28, two back-to-back frames of ramp data (value = index·0x0010 truncated, sign clear), out_ready=1 → 196 outputs per frame matching a golden max model. frame_done is seen on outputs 196 and 392 only.
- Backpressure: hold out_ready=0 for 5 cycles while out_valid=1 → in_ready=0, out_data/out_valid stable. No input is lost; the output sequence equals the no-stall run.
- Reset driven low for 1 cycle after 30 accepted pixels of a 28x28 frame → out_valid=0 immediately (asynchronous). A fresh full frame then yields 196 outputs matching the golden model, with no stale line-buffer effect.
